// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared address map for data_mem_bridge.
//   BTN_LEVEL_ADDR : debounced button levels (read-only)
//   BTN_PRESS_ADDR : sticky press latch (read-to-clear, write-1-to-clear)
//   WR_COUNT_ADDR  : saturating count of RAM writes (read-only)
//   dec_e          : result of decoding a CPU byte address
//   decode_addr()  : maps a full 32-bit address onto dec_e
package mem_map_pkg;

  localparam logic [31:0] BTN_LEVEL_ADDR = 32'h0000_8000;
  localparam logic [31:0] BTN_PRESS_ADDR = 32'h0000_8001;
  localparam logic [31:0] WR_COUNT_ADDR  = 32'h0000_8002;

  typedef enum logic [2:0] {
    DEC_RAM,
    DEC_LEVEL,
    DEC_PRESS,
    DEC_COUNT,
    DEC_BAD
  } dec_e;

  // The range check uses the whole address, so high bits can never alias
  // onto a RAM location.
  function automatic dec_e decode_addr(input logic [31:0] addr,
                                       input logic [31:0] depth);
    dec_e d;
    if (addr < depth)                d = DEC_RAM;
    else if (addr == BTN_LEVEL_ADDR) d = DEC_LEVEL;
    else if (addr == BTN_PRESS_ADDR) d = DEC_PRESS;
    else if (addr == WR_COUNT_ADDR)  d = DEC_COUNT;
    else                             d = DEC_BAD;
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button bit, raw asynchronous input to a debounced level.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   btn_i    : raw button
//   stable_o : debounced level
//   rise_o   : single-cycle pulse, high in the cycle whose closing edge
//              raises stable_o (so a latch fed by it sets on that same edge)
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // Toggle once the mismatch has been seen DEBOUNCE consecutive cycles.
  assign flip = (sync2_q != stable_q) && (cnt_q == CNT_MAX);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d    = '0;
      stable_d = ~stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = flip & ~stable_q;

endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: CPU data-memory port to byte RAM plus a peripheral window.
//   CLK, RST      : clock, asynchronous active-low reset
//   buttons_i     : raw buttons (NBTN)
//   addr_i        : CPU byte address
//   wdata_i       : write data, [7:0] for RAM, [NBTN-1:0] as W1C mask
//   we_i, re_i    : write / read strobes, one access each per cycle
//   rdata_o       : read data, zero-extended, held between reads
//   rd_valid_o    : one-cycle pulse marking rdata_o as fresh
//   err_o         : sticky out-of-map access flag
//   btn_stable_o  : debounced button levels
//
// Handshake: there is no back-pressure. A read accepted with re_i=1 in
// cycle n always produces rd_valid_o=1 with its data in cycle n+1; a
// write with we_i=1 commits on the edge closing cycle n.
module data_mem_bridge
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned NBTN     = 11,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] buttons_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  input  logic            we_i,
  input  logic            re_i,
  output logic [31:0]     rdata_o,
  output logic            rd_valid_o,
  output logic            err_o,
  output logic [NBTN-1:0] btn_stable_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WD_LO = (NBTN > 8) ? NBTN : 8;

  dec_e            dec;
  logic [AW-1:0]   ram_idx;
  logic [7:0]      mem [DEPTH];
  logic            ram_we;

  logic [NBTN-1:0] stable, rise;
  logic [NBTN-1:0] press_q, press_d, press_clr;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rd_valid_q;
  logic            err_q, err_d;
  logic            unused_wdata;

  assign dec     = decode_addr(addr_i, 32'(DEPTH));
  assign ram_idx = addr_i[AW-1:0];
  assign ram_we  = we_i && (dec == DEC_RAM);
  assign unused_wdata = ^wdata_i[31:WD_LO];

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .btn_i   (buttons_i[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i])
    );
  end

  // RAM contents are not reset. The read mux samples the array before the
  // write of the same edge lands, giving read-before-write.
  always_ff @(posedge CLK) begin
    if (ram_we) mem[ram_idx] <= wdata_i[7:0];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      case (dec)
        DEC_RAM:   rdata_d = {24'h0, mem[ram_idx]};
        DEC_LEVEL: rdata_d = 32'(stable);
        DEC_PRESS: rdata_d = 32'(press_q);
        DEC_COUNT: rdata_d = {16'h0, wr_cnt_q};
        default:   rdata_d = 32'h0;
      endcase
    end
  end

  always_comb begin
    err_d = err_q | ((re_i | we_i) && (dec == DEC_BAD));
  end

  // Read-clear and W1C mask combine; a rising debounced edge in the same
  // cycle is ORed in last so a new press is never lost.
  always_comb begin
    press_clr = '0;
    if (dec == DEC_PRESS) begin
      if (re_i) press_clr = press_clr | press_q;
      if (we_i) press_clr = press_clr | wdata_i[NBTN-1:0];
    end
    press_d = (press_q & ~press_clr) | rise;
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (ram_we && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata_q    <= 32'h0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      press_q    <= '0;
      wr_cnt_q   <= 16'h0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= re_i;
      err_q      <= err_d;
      press_q    <= press_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign rd_valid_o   = rd_valid_q;
  assign err_o        = err_q;
  assign btn_stable_o = stable;

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

  localparam int unsigned DEPTH    = 4096;
  localparam int unsigned NBTN     = 11;
  localparam int unsigned DEBOUNCE = 16;

  // ---------------- clock / reset ----------------
  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [NBTN-1:0] buttons_i = '0;
  logic [31:0]     addr_i = '0;
  logic [31:0]     wdata_i = '0;
  logic            we_i = 1'b0;
  logic            re_i = 1'b0;
  logic [31:0]     rdata_o;
  logic            rd_valid_o;
  logic            err_o;
  logic [NBTN-1:0] btn_stable_o;

  always #5 CLK = ~CLK;

  data_mem_bridge #(.DEPTH(DEPTH), .NBTN(NBTN), .DEBOUNCE(DEBOUNCE)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .buttons_i   (buttons_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .we_i        (we_i),
    .re_i        (re_i),
    .rdata_o     (rdata_o),
    .rd_valid_o  (rd_valid_o),
    .err_o       (err_o),
    .btn_stable_o(btn_stable_o)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let one rising edge pass, sample 1ns later.
  task automatic op(input logic we, input logic re,
                    input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge CLK);
    we_i = we; re_i = re; addr_i = addr; wdata_i = wdata;
    @(posedge CLK);
    #1;
    we_i = 1'b0; re_i = 1'b0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr,
                    input logic [31:0] exp);
    op(1'b0, 1'b1, addr, 32'h0);
    check({name, ".valid"}, 32'(rd_valid_o), 32'h1);
    check({name, ".data"}, rdata_o, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;   // rdata_o after the edge (held when re=0)
  } vec_t;

  vec_t vecs[16];

  initial begin
    int bad;
    vecs[0]  = '{"wr10_a5",   1, 0, 32'd10,    32'h0A5,  32'h00};
    vecs[1]  = '{"rd10",      0, 1, 32'd10,    32'h0,    32'hA5};
    vecs[2]  = '{"cnt1",      0, 1, 32'h8002,  32'h0,    32'h1};
    vecs[3]  = '{"rw10_rbw",  1, 1, 32'd10,    32'h03C,  32'hA5};
    vecs[4]  = '{"rd10_new",  0, 1, 32'd10,    32'h0,    32'h3C};
    vecs[5]  = '{"cnt2",      0, 1, 32'h8002,  32'h0,    32'h2};
    vecs[6]  = '{"wr_top",    1, 0, 32'd4095,  32'h1FF,  32'h2};
    vecs[7]  = '{"rd_top",    0, 1, 32'd4095,  32'h0,    32'hFF};
    vecs[8]  = '{"wr0",       1, 0, 32'd0,     32'h177,  32'hFF};
    vecs[9]  = '{"rd0",       0, 1, 32'd0,     32'h0,    32'h77};
    vecs[10] = '{"wr_level",  1, 0, 32'h8000,  32'hFFFF, 32'h77};
    vecs[11] = '{"wr_count",  1, 0, 32'h8002,  32'h1234, 32'h77};
    vecs[12] = '{"cnt4",      0, 1, 32'h8002,  32'h0,    32'h4};
    vecs[13] = '{"rd_level",  0, 1, 32'h8000,  32'h0,    32'h0};
    vecs[14] = '{"rd_press",  0, 1, 32'h8001,  32'h0,    32'h0};
    vecs[15] = '{"wr0_zero",  1, 0, 32'd0,     32'h000,  32'h0};

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst.rdata", rdata_o, 32'h0);
    check("rst.valid", 32'(rd_valid_o), 32'h0);
    check("rst.err", 32'(err_o), 32'h0);
    check("rst.stable", 32'(btn_stable_o), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // table-driven RAM / register accesses
    for (int i = 0; i < 16; i++) begin
      op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, ".valid"}, 32'(rd_valid_o), 32'(vecs[i].re));
      check({vecs[i].name, ".rdata"}, rdata_o, vecs[i].exp_rdata);
    end
    check("tbl.err", 32'(err_o), 32'h0);

    // write at DEPTH: out of map, must not alias onto address 0
    op(1'b1, 1'b0, 32'h1000, 32'h55);
    check("bad_wr.err", 32'(err_o), 32'h1);
    rd("bad_wr.noalias", 32'd0, 32'h00);
    rd("bad_wr.cnt", 32'h8002, 32'h5);

    // button 3: rises after 2 + DEBOUNCE edges
    @(negedge CLK);
    buttons_i[3] = 1'b1;
    repeat (17) @(posedge CLK);
    #1;
    check("btn3.before", 32'(btn_stable_o), 32'h000);
    @(posedge CLK);
    #1;
    check("btn3.after", 32'(btn_stable_o), 32'h008);
    rd("btn3.press", 32'h8001, 32'h008);
    rd("btn3.press2", 32'h8001, 32'h000);
    rd("btn3.level", 32'h8000, 32'h008);

    // 5-cycle glitch on button 0 must not get through
    @(negedge CLK);
    buttons_i[0] = 1'b1;
    repeat (5) @(negedge CLK);
    buttons_i[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK);
      #1;
      if (btn_stable_o !== 11'h008) bad++;
    end
    check("glitch.stable_changes", 32'(bad), 32'h0);
    rd("glitch.press", 32'h8001, 32'h000);

    // button 5: W1C lands on the same edge as the press; set wins
    @(negedge CLK);
    buttons_i[5] = 1'b1;
    repeat (17) @(posedge CLK);
    op(1'b1, 1'b0, 32'h8001, 32'h020);
    check("setwins.stable", 32'(btn_stable_o), 32'h028);
    rd("setwins.press", 32'h8001, 32'h020);

    // buttons 7 and 9 together; W1C of bit 7 only
    @(negedge CLK);
    buttons_i[7] = 1'b1;
    buttons_i[9] = 1'b1;
    repeat (20) @(posedge CLK);
    op(1'b1, 1'b0, 32'h8001, 32'h080);
    rd("w1c.press", 32'h8001, 32'h200);
    rd("w1c.level", 32'h8000, 32'h2A8);

    // reset the cycle after re_i: read aborted, everything cleared
    @(negedge CLK);
    buttons_i = '0;
    re_i = 1'b1;
    addr_i = 32'd10;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    re_i = 1'b0;
    addr_i = '0;
    #1;
    check("midrst.valid", 32'(rd_valid_o), 32'h0);
    check("midrst.rdata", rdata_o, 32'h0);
    check("midrst.err", 32'(err_o), 32'h0);
    check("midrst.stable", 32'(btn_stable_o), 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      if (rd_valid_o !== 1'b0) bad++;
    end
    check("midrst.no_valid", 32'(bad), 32'h0);
    rd("midrst.cnt", 32'h8002, 32'h0);
    rd("midrst.press", 32'h8001, 32'h0);

    // unmapped read: returns 0, err sticky until reset
    rd("rd10_pre", 32'd10, 32'h3C);
    rd("bad_rd", 32'h9000, 32'h0);
    check("bad_rd.err", 32'(err_o), 32'h1);
    rd("bad_rd.after", 32'd10, 32'h3C);
    repeat (4) @(posedge CLK);
    #1;
    check("bad_rd.sticky", 32'(err_o), 32'h1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("err_clr", 32'(err_o), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
